// File: rtl/mm_stream_host.sv
// mm_stream_host
//   Host-side driver/loopback partner for the matrix-multiply streaming engine.
//   Operand matrices A and B are written word-by-word into a local buffer.
//   On start, both are streamed out as one AXI4-Stream packet, A row-major
//   then B row-major, with tlast on the final word. The N x N row-major
//   result packet is then collected into a result buffer. That buffer is
//   readable through a registered read port.
//
// Ports
//   axis_aclk, axis_aresetn        clock, asynchronous active-low reset
//   ld_we, ld_addr, ld_data        operand write port (IDLE only)
//   start                          launch a transaction (IDLE only)
//   busy                           high while sending or receiving
//   done, err_tlast                sticky status, cleared by an accepted start
//   res_addr, res_data             result read port, 1-cycle latency
//   m0_axis_*                      operand stream master
//   s0_axis_*                      result stream slave (tstrb ignored)
module mm_stream_host #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      axis_aclk,
    input  logic                      axis_aresetn,

    input  logic                      ld_we,
    input  logic [ADDR_WIDTH-1:0]     ld_addr,
    input  logic [DATA_WIDTH-1:0]     ld_data,

    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      err_tlast,

    input  logic [ADDR_WIDTH-1:0]     res_addr,
    output logic [DATA_WIDTH-1:0]     res_data,

    output logic                      m0_axis_tvalid,
    output logic [DATA_WIDTH-1:0]     m0_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m0_axis_tstrb,
    output logic                      m0_axis_tlast,
    input  logic                      m0_axis_tready,

    input  logic                      s0_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]     s0_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s0_axis_tstrb,
    input  logic                      s0_axis_tlast,
    output logic                      s0_axis_tready
);

    localparam int unsigned OP_WORDS  = 2 * N * N;
    localparam int unsigned RES_WORDS = N * N;
    localparam int          OP_AW     = $clog2(OP_WORDS);
    localparam int          RES_AW    = $clog2(RES_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV} state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [DATA_WIDTH-1:0]  op_mem  [OP_WORDS];
    logic [DATA_WIDTH-1:0]  res_mem [RES_WORDS];

    logic [ADDR_WIDTH-1:0]  tx_cnt;
    logic [ADDR_WIDTH-1:0]  tx_nxt;
    logic [ADDR_WIDTH-1:0]  rx_cnt;
    logic                   m0_hs;
    logic                   s0_hs;
    logic                   tx_final;
    logic                   rx_final;
    logic                   ld_ok;
    logic                   start_ok;
    logic                   unused_s0_tstrb;

    assign m0_hs    = m0_axis_tvalid & m0_axis_tready;
    assign s0_hs    = s0_axis_tvalid & s0_axis_tready;
    assign tx_nxt   = tx_cnt + 1'b1;
    assign tx_final = (32'(tx_cnt) == OP_WORDS - 1);
    assign rx_final = (32'(rx_cnt) == RES_WORDS - 1);
    assign start_ok = start & (state == S_IDLE);
    // Operands are frozen outside IDLE so the packet in flight stays coherent.
    assign ld_ok    = ld_we & (state == S_IDLE) & (32'(ld_addr) < OP_WORDS);

    assign m0_axis_tstrb   = '1;
    assign unused_s0_tstrb = ^s0_axis_tstrb;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) state <= S_IDLE;
        else               state <= state_nxt;
    end

    // NOTE: each combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok)           state_nxt = S_SEND;
            S_SEND:  if (m0_hs && tx_final)  state_nxt = S_RECV;
            S_RECV:  if (s0_hs && rx_final)  state_nxt = S_IDLE;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    // Stream controls decode the registered state, so they are glitch-free
    // and drop the instant reset is asserted.
    always_comb begin
        busy           = 1'b0;
        m0_axis_tvalid = 1'b0;
        s0_axis_tready = 1'b0;
        case (state)
            S_SEND: begin
                busy           = 1'b1;
                m0_axis_tvalid = 1'b1;
            end
            S_RECV: begin
                busy           = 1'b1;
                s0_axis_tready = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            tx_cnt        <= '0;
            rx_cnt        <= '0;
            m0_axis_tdata <= '0;
            m0_axis_tlast <= 1'b0;
            done          <= 1'b0;
            err_tlast     <= 1'b0;
            res_data      <= '0;
        end else begin
            if (start_ok) begin
                tx_cnt        <= '0;
                m0_axis_tdata <= op_mem[0];
                m0_axis_tlast <= 1'b0;
                done          <= 1'b0;
                err_tlast     <= 1'b0;
            end

            // Next word is preloaded on each handshake, giving one word per
            // cycle under continuous tready and holding the word on a stall.
            if (m0_hs) begin
                if (tx_final) begin
                    m0_axis_tlast <= 1'b0;
                    rx_cnt        <= '0;
                end else begin
                    tx_cnt        <= tx_nxt;
                    m0_axis_tdata <= op_mem[tx_nxt[OP_AW-1:0]];
                    m0_axis_tlast <= (32'(tx_nxt) == OP_WORDS - 1);
                end
            end

            // Always take exactly N*N beats; a misplaced tlast only flags.
            if (s0_hs) begin
                if (s0_axis_tlast != rx_final) err_tlast <= 1'b1;
                if (rx_final)                  done      <= 1'b1;
                rx_cnt <= rx_cnt + 1'b1;
            end

            res_data <= (32'(res_addr) < RES_WORDS) ? res_mem[res_addr[RES_AW-1:0]] : '0;
        end
    end

    // NOTE: the buffers carry no reset; their contents survive reset and
    // leaving them out of the reset tree lets them map onto RAM.
    always_ff @(posedge axis_aclk) begin
        if (ld_ok) op_mem[ld_addr[OP_AW-1:0]] <= ld_data;
    end

    always_ff @(posedge axis_aclk) begin
        if (s0_hs) res_mem[rx_cnt[RES_AW-1:0]] <= s0_axis_tdata;
    end

endmodule

// File: tb/tb_mm_stream_host.sv
module tb_mm_stream_host;

    localparam int DW   = 32;
    localparam int N    = 8;
    localparam int AW   = 8;
    localparam int OPW  = 2 * N * N;
    localparam int RESW = N * N;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic            clk = 1'b0;
    logic            axis_aresetn;
    logic            ld_we;
    logic [AW-1:0]   ld_addr;
    logic [DW-1:0]   ld_data;
    logic            start;
    logic            busy, done, err_tlast;
    logic [AW-1:0]   res_addr;
    logic [DW-1:0]   res_data;
    logic            m0_axis_tvalid, m0_axis_tlast, m0_axis_tready;
    logic [DW-1:0]   m0_axis_tdata;
    logic [DW/8-1:0] m0_axis_tstrb;
    logic            s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
    logic [DW-1:0]   s0_axis_tdata;
    logic [DW/8-1:0] s0_axis_tstrb;

    always #5 clk = ~clk;

    mm_stream_host #(.DATA_WIDTH(DW), .N(N), .ADDR_WIDTH(AW)) dut (
        .axis_aclk      (clk),
        .axis_aresetn   (axis_aresetn),
        .ld_we          (ld_we),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .err_tlast      (err_tlast),
        .res_addr       (res_addr),
        .res_data       (res_data),
        .m0_axis_tvalid (m0_axis_tvalid),
        .m0_axis_tdata  (m0_axis_tdata),
        .m0_axis_tstrb  (m0_axis_tstrb),
        .m0_axis_tlast  (m0_axis_tlast),
        .m0_axis_tready (m0_axis_tready),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tstrb  (s0_axis_tstrb),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_tready (s0_axis_tready)
    );

    // Reference model: operand image, expected result image, expectations.
    logic [DW-1:0] op_model  [OPW];
    logic [DW-1:0] res_model [RESW];
    bit            model_busy;
    beat_t         exp_q[$];
    logic [DW-1:0] rd_q[$];
    int            beat_cnt, first_cyc, last_cyc, cyc;
    int            n_checks, n_errors;
    int            tready_mode;
    logic          rd_req, rd_req_d;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // m0 sink: tready pattern selected by tready_mode.
    initial begin
        m0_axis_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (tready_mode)
                0:       m0_axis_tready = 1'b1;
                1:       m0_axis_tready = ~m0_axis_tready;
                default: m0_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // m0 monitor: compares each accepted beat with the scoreboard and checks
    // that a stalled beat is held unchanged.
    bit            stall_prev;
    logic [DW-1:0] held_d;
    logic          held_l;
    always @(negedge clk) begin
        beat_t e;
        if (!axis_aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check1("m0_tvalid_held", m0_axis_tvalid, 1'b1);
                check("m0_tdata_stable", m0_axis_tdata, held_d);
                check1("m0_tlast_stable", m0_axis_tlast, held_l);
            end
            if (m0_axis_tvalid && m0_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL m0_extra_beat: got %0h, expected no beat", m0_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("m0_tdata", m0_axis_tdata, e.d);
                    check1("m0_tlast", m0_axis_tlast, e.l);
                end
                if (beat_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat_cnt++;
            end
            stall_prev = m0_axis_tvalid && !m0_axis_tready;
            held_d     = m0_axis_tdata;
            held_l     = m0_axis_tlast;
        end
    end

    // Read-port monitor: one-cycle latency after a request.
    always @(posedge clk or negedge axis_aresetn) begin
        if (!axis_aresetn) rd_req_d <= 1'b0;
        else               rd_req_d <= rd_req;
    end

    always @(negedge clk) begin
        if (rd_req_d) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL res_data_extra: got %0h, expected no read", res_data);
            end else begin
                check("res_data", res_data, rd_q.pop_front());
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic load(input int addr, input logic [DW-1:0] data);
        ld_we   = 1'b1;
        ld_addr = AW'(addr);
        ld_data = data;
        if (!model_busy && addr < OPW) op_model[addr] = data;
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    task automatic do_start();
        for (int i = 0; i < OPW; i++) exp_q.push_back('{d: op_model[i], l: (i == OPW - 1)});
        beat_cnt   = 0;
        model_busy = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check1("start_busy", busy, 1'b1);
        check1("start_clears_done", done, 1'b0);
        check1("start_clears_err", err_tlast, 1'b0);
    endtask

    task automatic send_result(input int err_beat, input bit gaps, input bit pulse_start, input bit rand_data);
        bit hs;
        for (int k = 0; k < RESW; k++) begin
            if (gaps) begin
                s0_axis_tvalid = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            res_model[k]   = rand_data ? $urandom : DW'(1000 + k);
            s0_axis_tvalid = 1'b1;
            s0_axis_tdata  = res_model[k];
            s0_axis_tstrb  = 4'($urandom);
            s0_axis_tlast  = (err_beat < 0) ? (k == RESW - 1) : (k == err_beat);
            if (pulse_start) start = (k == 20);
            hs = 1'b0;
            for (int w = 0; w < 4000 && !hs; w++) begin
                @(negedge clk);
                hs = s0_axis_tready;
                @(posedge clk); #1;
            end
            check1("s0_handshake", hs, 1'b1);
            if (!hs) break;
        end
        s0_axis_tvalid = 1'b0;
        s0_axis_tlast  = 1'b0;
        start          = 1'b0;
    endtask

    task automatic wait_done(input bit err_exp);
        for (int w = 0; w < 200 && !done; w++) begin @(posedge clk); #1; end
        check1("done", done, 1'b1);
        check1("err_tlast", err_tlast, err_exp);
        check1("idle_busy", busy, 1'b0);
        check("beats_sent", beat_cnt, OPW);
        check("beats_left", exp_q.size(), 0);
        model_busy = 1'b0;
    endtask

    task automatic rd(input int addr, input logic [DW-1:0] exp);
        res_addr = AW'(addr);
        rd_q.push_back(exp);
        rd_req = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic read_all();
        for (int k = 0; k < RESW; k++) rd(k, res_model[k]);
        rd(RESW, '0);
        rd(200, '0);
        @(posedge clk); #1;
        check("reads_left", rd_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        axis_aresetn   = 1'b0;
        ld_we          = 1'b0;
        ld_addr        = '0;
        ld_data        = '0;
        start          = 1'b0;
        res_addr       = '0;
        s0_axis_tvalid = 1'b0;
        s0_axis_tdata  = '0;
        s0_axis_tstrb  = '0;
        s0_axis_tlast  = 1'b0;
        rd_req         = 1'b0;
        tready_mode    = 0;
        model_busy     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err_tlast, 1'b0);
        check1("rst_m0_tvalid", m0_axis_tvalid, 1'b0);
        check1("rst_m0_tlast", m0_axis_tlast, 1'b0);
        check1("rst_s0_tready", s0_axis_tready, 1'b0);
        check("rst_m0_tdata", m0_axis_tdata, '0);
        check("rst_res_data", res_data, '0);
        check("rst_tstrb", 32'(m0_axis_tstrb), 32'hF);
        axis_aresetn = 1'b1;
        @(posedge clk); #1;

        // Full transaction: A = identity, B[r][c] = r*8+c, continuous tready.
        for (int i = 0; i < OPW; i++) begin
            int r, c;
            r = (i % RESW) / N;
            c = i % N;
            load(i, (i < RESW) ? ((r == c) ? 32'd1 : 32'd0) : 32'(r * N + c));
        end
        load(200, 32'hDEADBEEF);
        tready_mode = 0;
        do_start();
        send_result(-1, 1'b0, 1'b0, 1'b0);
        wait_done(1'b0);
        check("no_bubbles", last_cyc - first_cyc, OPW - 1);
        read_all();

        // Backpressure: random operands, toggling tready, gapped results,
        // and a write to word 5 during SEND that must be ignored.
        for (int i = 0; i < OPW; i++) load(i, $urandom);
        tready_mode = 1;
        do_start();
        load(5, ~op_model[5]);
        send_result(-1, 1'b1, 1'b0, 1'b1);
        wait_done(1'b0);
        read_all();

        // tlast on beat 10 and not on beat 63; start pulsed during RECV.
        tready_mode = 2;
        do_start();
        send_result(10, 1'b1, 1'b1, 1'b1);
        wait_done(1'b1);
        read_all();
        check1("no_restart_busy", busy, 1'b0);
        check1("no_restart_tvalid", m0_axis_tvalid, 1'b0);
        check("no_restart_beats", beat_cnt, OPW);

        // Next start clears both flags and runs cleanly.
        tready_mode = 0;
        do_start();
        send_result(-1, 1'b0, 1'b0, 1'b1);
        wait_done(1'b0);
        read_all();

        // Reset asserted mid-SEND at beat 50, then a fresh transaction.
        do_start();
        for (int w = 0; w < 500 && beat_cnt < 50; w++) @(posedge clk);
        #2;
        axis_aresetn = 1'b0;
        #1;
        check1("midrst_m0_tvalid", m0_axis_tvalid, 1'b0);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_s0_tready", s0_axis_tready, 1'b0);
        check1("midrst_m0_tlast", m0_axis_tlast, 1'b0);
        exp_q.delete();
        model_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        axis_aresetn = 1'b1;
        @(posedge clk); #1;
        do_start();
        send_result(-1, 1'b0, 1'b0, 1'b1);
        wait_done(1'b0);
        read_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
